pc_fetch_unit: RTL and testbench

- Sequential front end of the LEGv8 datapath.
- Holds the architectural program counter and fetches the 32-bit instruction at that address from instruction memory over a req/ack handshake.
- Presents the PC and instruction to decode and to the next-PC logic.
- On advance from the control unit, loads the nextPC computed downstream and starts the next fetch.

---
 rtl/pc_fetch_unit_pkg.sv | 15 +
 rtl/pc_fetch_unit_if.sv | 25 ++
 rtl/pc_fetch_unit_pc_register.sv | 22 ++
 rtl/pc_fetch_unit.sv | 118 +++++++++++
 tb/tb_pc_fetch_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the LEGv8 fetch front end.
// No logic; imported by the fetch unit and its bench.
package legv8_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        READY = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam int          ALIGN_BITS       = $clog2(INSTR_BYTES);
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory req/ack channel: fetch unit is master, memory is slave.
// Request is held until ack; memory latency is unbounded.
interface pc_fetch_unit_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               imemReq;
    logic [ADDR_W-1:0]  imemAddr;
    logic               imemAck;
    logic [INSTR_W-1:0] imemData;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemAck,
        input  imemData
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemAck,
        output imemData
    );
endinterface

// File: rtl/pc_fetch_unit_pc_register.sv
// Loadable program-counter register, async active-low reset to RESET_PC.
// One-cycle load latency; holds value when load is low.
module pc_register #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// LEGv8 PC + instruction fetch: ack -> instrValid in 1 cycle, 1 instr / 2 cycles max.
// Advance is blocked by stall and ignored outside READY; PC_ALIGN_CHECK_EN adds the FAULT trap.
module pc_fetch_unit
    import legv8_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic                CLK,
    input  logic                resetl,
    input  logic [ADDR_W-1:0]   nextPC,
    input  logic                advance,
    input  logic                stall,
    pc_fetch_unit_if.master     imem,
    output logic [ADDR_W-1:0]   currentPC,
    output logic [INSTR_W-1:0]  instruction,
    output logic                instrValid,
    output logic [31:0]         retiredCount,
    output logic                pcFault
);

    fetch_state_t       state;
    logic               req_q;
    logic [INSTR_W-1:0] instr_q;
    logic               vld_q;
    logic [31:0]        retired_q;
    logic               fault_q;

    logic               advance_ok;
    logic               pc_load;
    logic [ADDR_W-1:0]  pc_d;

    assign advance_ok = (state == READY) && advance && !stall;

`ifdef PC_ALIGN_CHECK_EN
    logic aligned;
    assign aligned = (nextPC[ALIGN_BITS-1:0] == '0);
    assign pc_load = advance_ok && aligned;
    assign pc_d    = nextPC;
`else
    // Low bits are cleared rather than trapped when alignment checking is off.
    assign pc_load = advance_ok;
    assign pc_d    = nextPC & ~ADDR_W'(INSTR_BYTES - 1);
`endif

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk   (CLK),
        .rst_n (resetl),
        .load  (pc_load),
        .d     (pc_d),
        .q     (currentPC)
    );

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state     <= FETCH;
            req_q     <= 1'b0;
            instr_q   <= '0;
            vld_q     <= 1'b0;
            retired_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    // Ack only counts against a request that is already on the wire.
                    if (req_q && imem.imemAck) begin
                        instr_q <= imem.imemData;
                        vld_q   <= 1'b1;
                        req_q   <= 1'b0;
                        state   <= READY;
                    end else begin
                        req_q   <= 1'b1;
                    end
                end
                READY: begin
                    if (advance_ok) begin
                        retired_q <= retired_q + 32'd1;
                        vld_q     <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
                        if (!aligned) begin
                            fault_q <= 1'b1;
                            req_q   <= 1'b0;
                            state   <= FAULT;
                        end else begin
                            req_q   <= 1'b1;
                            state   <= FETCH;
                        end
`else
                        req_q     <= 1'b1;
                        state     <= FETCH;
`endif
                    end
                end
                FAULT: begin
                    req_q <= 1'b0;
                    vld_q <= 1'b0;
                end
                default: begin
                    req_q <= 1'b0;
                    vld_q <= 1'b0;
                    state <= FETCH;
                end
            endcase
        end
    end

    assign imem.imemReq  = req_q;
    assign imem.imemAddr = currentPC;
    assign instruction   = instr_q;
    assign instrValid    = vld_q;
    assign retiredCount  = retired_q;
    assign pcFault       = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: inputs driven and outputs sampled on the falling edge.
module tb_pc_fetch_unit;
    import legv8_fetch_pkg::*;

    logic        CLK;
    logic        resetl;
    logic [63:0] nextPC;
    logic        advance;
    logic        stall;
    logic [63:0] currentPC;
    logic [31:0] instruction;
    logic        instrValid;
    logic [31:0] retiredCount;
    logic        pcFault;

    int checks;
    int failures;

    pc_fetch_unit_if #(.ADDR_W(64), .INSTR_W(32)) imem ();

    pc_fetch_unit #(
        .ADDR_W   (64),
        .INSTR_W  (32),
        .RESET_PC (64'h0)
    ) dut (
        .CLK          (CLK),
        .resetl       (resetl),
        .nextPC       (nextPC),
        .advance      (advance),
        .stall        (stall),
        .imem         (imem),
        .currentPC    (currentPC),
        .instruction  (instruction),
        .instrValid   (instrValid),
        .retiredCount (retiredCount),
        .pcFault      (pcFault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        resetl = 1'b0; nextPC = '0; advance = 1'b0; stall = 1'b0;
        imem.imemAck = 1'b0; imem.imemData = '0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({currentPC, instruction, instrValid, imem.imemReq, retiredCount, pcFault}
            !== {64'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: pc=%h instr=%h vld=%b req=%b cnt=%0d fault=%b expected all zero",
                     currentPC, instruction, instrValid, imem.imemReq, retiredCount, pcFault);
        end
        resetl = 1'b1;
        @(negedge CLK);
        checks++;
        if (imem.imemReq !== 1'b1) begin
            failures++;
            $display("FAIL first_req: got %b expected 1", imem.imemReq);
        end
        checks++;
        if (imem.imemAddr !== 64'h0) begin
            failures++;
            $display("FAIL first_addr: got %h expected 0", imem.imemAddr);
        end
        imem.imemAck = 1'b1; imem.imemData = 32'h8B020020;
        @(negedge CLK);
        imem.imemAck = 1'b0;
        checks++;
        if ({instruction, instrValid, imem.imemReq} !== {32'h8B020020, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL same_cycle_ack: instr=%h vld=%b req=%b expected 8b020020 1 0",
                     instruction, instrValid, imem.imemReq);
        end
    endtask

    task automatic test_advance();
        nextPC = 64'h1010; advance = 1'b1;
        @(negedge CLK);
        advance = 1'b0;
        chk64("adv_pc", currentPC, 64'h1010);
        checks++;
        if ({instrValid, imem.imemReq} !== 2'b01) begin
            failures++;
            $display("FAIL adv_flags: vld=%b req=%b expected 0 1", instrValid, imem.imemReq);
        end
        chk64("adv_count", 64'(retiredCount), 64'd1);
    endtask

    task automatic test_delayed_ack();
        // Advance pulsed while fetching must be ignored.
        nextPC = 64'h3000;
        for (int i = 0; i < 3; i++) begin
            advance = (i == 1);
            @(negedge CLK);
            checks++;
            if ({imem.imemReq, imem.imemAddr, instrValid} !== {1'b1, 64'h1010, 1'b0}) begin
                failures++;
                $display("FAIL delayed_hold[%0d]: req=%b addr=%h vld=%b expected 1 1010 0",
                         i, imem.imemReq, imem.imemAddr, instrValid);
            end
        end
        advance = 1'b0;
        imem.imemAck = 1'b1; imem.imemData = 32'hF84003E1;
        @(negedge CLK);
        imem.imemAck = 1'b0;
        checks++;
        if ({instrValid, instruction, imem.imemReq} !== {1'b1, 32'hF84003E1, 1'b0}) begin
            failures++;
            $display("FAIL delayed_ack: vld=%b instr=%h req=%b expected 1 f84003e1 0",
                     instrValid, instruction, imem.imemReq);
        end
        chk64("fetch_adv_ignored_pc", currentPC, 64'h1010);
        chk64("fetch_adv_ignored_cnt", 64'(retiredCount), 64'd1);
    endtask

    task automatic test_stall();
        nextPC = 64'h2000; advance = 1'b1; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if ({currentPC, instrValid, retiredCount} !== {64'h1010, 1'b1, 32'd1}) begin
                failures++;
                $display("FAIL stall_hold[%0d]: pc=%h vld=%b cnt=%0d expected 1010 1 1",
                         i, currentPC, instrValid, retiredCount);
            end
        end
        stall = 1'b0;
        @(negedge CLK);
        advance = 1'b0;
        checks++;
        if ({currentPC, retiredCount, imem.imemReq} !== {64'h2000, 32'd2, 1'b1}) begin
            failures++;
            $display("FAIL stall_release: pc=%h cnt=%0d req=%b expected 2000 2 1",
                     currentPC, retiredCount, imem.imemReq);
        end
        imem.imemAck = 1'b1; imem.imemData = 32'h91000421;
        @(negedge CLK);
        imem.imemAck = 1'b0;
        chk64("stall_refetch_vld", 64'(instrValid), 64'd1);
    endtask

    task automatic test_wrap();
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        nextPC = 64'h2004; advance = 1'b1;
        @(negedge CLK);
        advance = 1'b0;
        chk64("wrap_count", 64'(retiredCount), 64'd0);
        chk64("wrap_pc", currentPC, 64'h2004);
        imem.imemAck = 1'b1; imem.imemData = 32'hD65F03C0;
        @(negedge CLK);
        imem.imemAck = 1'b0;
        chk64("wrap_refetch_vld", 64'(instrValid), 64'd1);
    endtask

    task automatic test_misalign();
        nextPC = 64'h2002; advance = 1'b1;
        @(negedge CLK);
        advance = 1'b0;
        chk64("misalign_count", 64'(retiredCount), 64'd1);
`ifdef PC_ALIGN_CHECK_EN
        chk64("misalign_pc_held", currentPC, 64'h2004);
        checks++;
        if ({pcFault, imem.imemReq, instrValid} !== 3'b100) begin
            failures++;
            $display("FAIL misalign_fault: fault=%b req=%b vld=%b expected 1 0 0",
                     pcFault, imem.imemReq, instrValid);
        end
        imem.imemAck = 1'b1; nextPC = 64'h3000; advance = 1'b1;
        repeat (3) @(negedge CLK);
        imem.imemAck = 1'b0; advance = 1'b0;
        checks++;
        if ({pcFault, imem.imemReq, currentPC, retiredCount} !== {1'b1, 1'b0, 64'h2004, 32'd1}) begin
            failures++;
            $display("FAIL fault_sticky: fault=%b req=%b pc=%h cnt=%0d expected 1 0 2004 1",
                     pcFault, imem.imemReq, currentPC, retiredCount);
        end
        resetl = 1'b0;
        #1;
        chk64("fault_cleared", 64'(pcFault), 64'd0);
        @(negedge CLK);
        resetl = 1'b1;
`else
        chk64("misalign_pc_forced", currentPC, 64'h2000);
        chk64("misalign_no_fault", 64'(pcFault), 64'd0);
        chk64("misalign_req", 64'(imem.imemReq), 64'd1);
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_advance();
        test_delayed_ack();
        test_stall();
        test_wrap();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
